// File: rtl/fpu_sched.sv
// Shares one FPU among NUM_REQ requesters using round-robin issue.
// Each issued op is tagged with its requester ID so the in-order result can be routed back.
//   state    | meaning
//   S_IDLE   | nothing in flight
//   S_ACTIVE | ops in flight, granting enabled
//   S_DRAIN  | ops in flight, granting disabled, waiting for results
module fpu_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 1,
    parameter int MAX_OUT    = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_en,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data_b,
    input  logic [NUM_REQ*INST_WIDTH-1:0]    i_req_inst,
    output logic [NUM_REQ-1:0]               o_req_ready,
    output logic [DATA_WIDTH-1:0]            o_fpu_data_a,
    output logic [DATA_WIDTH-1:0]            o_fpu_data_b,
    output logic [INST_WIDTH-1:0]            o_fpu_inst,
    output logic                             o_fpu_valid,
    input  logic [DATA_WIDTH-1:0]            i_fpu_data,
    input  logic                             i_fpu_valid,
    output logic                             o_rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]       o_rsp_id,
    output logic [DATA_WIDTH-1:0]            o_rsp_data,
    output logic                             o_idle,
    output logic                             o_err
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(MAX_OUT);
    localparam int CW  = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [IDW-1:0]          rr_q;
    logic [IDW-1:0]          fifo_q [MAX_OUT];
    logic [PW-1:0]           wr_q, rd_q;
    logic                    fpu_valid_q;
    logic [DATA_WIDTH-1:0]   fpu_a_q, fpu_b_q;
    logic [INST_WIDTH-1:0]   fpu_inst_q;
    logic                    rsp_valid_q;
    logic [IDW-1:0]          rsp_id_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   req_a    [NUM_REQ];
    logic [DATA_WIDTH-1:0]   req_b    [NUM_REQ];
    logic [INST_WIDTH-1:0]   req_inst [NUM_REQ];

    logic                    allowed, gnt_any, push, pop;
    logic [IDW-1:0]          gnt_idx;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_a[k]    = i_req_data_a[k*DATA_WIDTH +: DATA_WIDTH];
        assign req_b[k]    = i_req_data_b[k*DATA_WIDTH +: DATA_WIDTH];
        assign req_inst[k] = i_req_inst[k*INST_WIDTH +: INST_WIDTH];
    end

    // Reset gates the grant so nothing handshakes while the block is held in reset.
    assign allowed = i_rst_n && i_en && (count_q < CW'(MAX_OUT));

    always_comb begin
        int j;
        gnt_any = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!gnt_any && i_req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
    end

    assign o_req_ready = (allowed && gnt_any) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign push        = allowed && gnt_any;
    assign pop         = i_fpu_valid && (count_q != '0);
    assign count_d     = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (push) state_d = S_ACTIVE;
            S_ACTIVE: if (count_d == '0) state_d = S_IDLE;
                      else if (!i_en) state_d = S_DRAIN;
            S_DRAIN:  if (count_d == '0) state_d = S_IDLE;
                      else if (i_en) state_d = S_ACTIVE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rr_q        <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            fpu_valid_q <= 1'b0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_inst_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            fpu_valid_q <= push;
            rsp_valid_q <= pop;
            if (push) begin
                fpu_a_q      <= req_a[gnt_idx];
                fpu_b_q      <= req_b[gnt_idx];
                fpu_inst_q   <= req_inst[gnt_idx];
                rr_q         <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
                fifo_q[wr_q] <= gnt_idx;
                wr_q         <= wr_q + PW'(1);
            end
            if (pop) begin
                rsp_id_q   <= fifo_q[rd_q];
                rsp_data_q <= i_fpu_data;
                rd_q       <= rd_q + PW'(1);
            end
            if (i_fpu_valid && (count_q == '0)) err_q <= 1'b1;
        end
    end

    assign o_fpu_valid  = fpu_valid_q;
    assign o_fpu_data_a = fpu_a_q;
    assign o_fpu_data_b = fpu_b_q;
    assign o_fpu_inst   = fpu_inst_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_data   = rsp_data_q;
    assign o_err        = err_q;
    assign o_idle       = (state_q == S_IDLE) && !fpu_valid_q;

endmodule
